// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, lane count and word-index helper for the data-memory responder.
package dmem_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} dmem_state_t;
  localparam int WORD_BYTES = 4;
  function automatic logic [63:0] word_index(input logic [63:0] a);
    return a >> 2;
  endfunction
endpackage

// File: rtl/dmem_sram_bank.sv
// dmem_sram_bank: single-port word array with per-byte write enables and a registered read port.
module dmem_sram_bank import dmem_pkg::*; #(
  parameter int DEPTH_WORDS = 1024,
  parameter int DATA_WIDTH  = 32,
  parameter int IW          = $clog2(DEPTH_WORDS)
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [WORD_BYTES-1:0] be_i,
  input  logic [IW-1:0]         addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];
  always_ff @(posedge clk) begin
    for (int b = 0; b < WORD_BYTES; b++)
      if (we_i && be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: data-port responder with wait states, byte-enabled writes and single-cycle ready.
// Optional fault reporting enabled by defining DMEM_ACCESS_FAULT_EN.
module dmem_responder import dmem_pkg::*; #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] dmem_addr,
  input  logic [DATA_WIDTH-1:0] dmem_write_data,
  input  logic                  dmem_read,
  input  logic                  dmem_write,
  input  logic [WORD_BYTES-1:0] dmem_byte_enable,
  output logic [DATA_WIDTH-1:0] dmem_read_data,
  output logic                  dmem_ready,
  output logic                  busy,
  output logic                  access_fault
);
  localparam int IW = $clog2(DEPTH_WORDS);
  dmem_state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_in;
  logic [DATA_WIDTH-1:0] wdata_q, rdata;
  logic [WORD_BYTES-1:0] be_q;
  logic wr_q, oor_q, req, oor, accept;
  assign req = dmem_read | dmem_write;
  assign idx_in = IW'(word_index(64'(dmem_addr)));
  assign oor = |(dmem_addr >> (IW + 2));
  assign accept = state_q == IDLE && req;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    unique case (state_q)
      IDLE: if (req) begin
        state_d = WAIT_STATES > 0 ? WAIT : RESP;
        cnt_d = 4'(WAIT_STATES);
      end
      WAIT: begin
        state_d = !req ? IDLE : cnt_q == 4'd1 ? RESP : WAIT;
        cnt_d = (!req || cnt_q == 4'd1) ? 4'd0 : cnt_q - 4'd1;
      end
      default: begin
        state_d = IDLE;
        cnt_d = 4'd0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      wdata_q <= '0;
      be_q <= '0;
      wr_q <= 1'b0;
      oor_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      if (accept) begin
        idx_q <= idx_in;
        wdata_q <= dmem_write_data;
        be_q <= dmem_byte_enable;
        wr_q <= dmem_write;
        oor_q <= oor;
      end
    end
  end
  // Array is addressed by the live index while idle so the word is ready on entry to RESP even with zero wait states.
  dmem_sram_bank #(.DEPTH_WORDS(DEPTH_WORDS), .DATA_WIDTH(DATA_WIDTH)) u_bank (
    .clk(clk),
    .we_i(dmem_ready && wr_q && !oor_q),
    .be_i(be_q),
    .addr_i(state_q == IDLE ? idx_in : idx_q),
    .wdata_i(wdata_q),
    .rdata_o(rdata)
  );
  assign dmem_ready = state_q == RESP && req;
  assign dmem_read_data = (dmem_ready && !oor_q) ? rdata : '0;
  assign busy = state_q != IDLE;
`ifdef DMEM_ACCESS_FAULT_EN
  logic flt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) flt_q <= 1'b0;
    else if (accept) flt_q <= oor | (dmem_read & dmem_write);
  assign access_fault = dmem_ready & flt_q;
`else
  assign access_fault = 1'b0;
`endif
endmodule
